// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: fetch sequencer links to the hazard unit, IF stage and IF/ID register.
interface fetch_ctrl_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic        halted;
  logic        fault;
  logic [15:0] fetch_count;
  logic [15:0] bubble_count;
  modport master (
    input  stall, branch_taken, branch_target, imem_instr,
    output imem_addr, ifid_instr, ifid_pc4, ifid_valid, halted, fault, fetch_count, bubble_count
  );
  modport slave (
    output stall, branch_taken, branch_target, imem_instr,
    input  imem_addr, ifid_instr, ifid_pc4, ifid_valid, halted, fault, fetch_count, bubble_count
  );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC owner, IF/ID register and halt drain sequencer; FETCH_PERF_CNT_EN adds fetch/bubble counters.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int unsigned MEM_BYTES    = 52,
  parameter logic [31:0] HALT_WORD    = 32'hFFFF_FFFF,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic         clk,
  input  logic         reset,
  fetch_ctrl_if.master bus
);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  localparam logic [31:0] LAST_PC  = 32'(MEM_BYTES - 4);
  localparam logic [3:0]  LAST_CNT = 4'(DRAIN_CYCLES - 1);
  state_t      state, state_n;
  logic [31:0] pc, pc_n, instr, pc4;
  logic [3:0]  cnt, cnt_n;
  logic        valid, flt, flt_n, load, bubble, oob, detect;
  logic        unused_lsb;
  assign unused_lsb = ^bus.branch_target[1:0];
  assign oob        = pc > LAST_PC;
  assign detect     = oob || (bus.imem_instr == HALT_WORD);
  // The halt-detect edge is itself the first drain bubble, so DRAIN lasts DRAIN_CYCLES-1 cycles.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    cnt_n   = cnt;
    flt_n   = flt;
    load    = 1'b0;
    bubble  = 1'b0;
    if (state != HALTED) begin
      if (bus.branch_taken) begin
        pc_n    = {bus.branch_target[31:2], 2'b00};
        cnt_n   = '0;
        bubble  = 1'b1;
        state_n = RUN;
      end else if (state == DRAIN) begin
        if (!bus.stall) begin
          cnt_n   = cnt + 4'd1;
          bubble  = 1'b1;
          state_n = (cnt_n == LAST_CNT) ? HALTED : DRAIN;
        end
      end else if (detect) begin
        flt_n   = flt | oob;
        cnt_n   = '0;
        bubble  = 1'b1;
        state_n = (LAST_CNT == 4'd0) ? HALTED : DRAIN;
      end else if (!bus.stall) begin
        load = 1'b1;
        pc_n = pc + 32'd4;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      pc    <= RESET_PC;
      cnt   <= '0;
      flt   <= 1'b0;
      instr <= '0;
      pc4   <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      cnt   <= cnt_n;
      flt   <= flt_n;
      if (load || bubble) begin
        instr <= load ? bus.imem_instr : '0;
        pc4   <= load ? pc + 32'd4 : '0;
        valid <= load;
      end
    end
  end
  assign bus.imem_addr  = pc;
  assign bus.ifid_instr = instr;
  assign bus.ifid_pc4   = pc4;
  assign bus.ifid_valid = valid;
  assign bus.halted     = state == HALTED;
  assign bus.fault      = flt;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fcnt, bcnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fcnt <= '0;
      bcnt <= '0;
    end else begin
      if (load && fcnt != 16'hFFFF) fcnt <= fcnt + 16'd1;
      if (bubble && bcnt != 16'hFFFF) bcnt <= bcnt + 16'd1;
    end
  end
  assign bus.fetch_count  = fcnt;
  assign bus.bubble_count = bcnt;
`else
  assign bus.fetch_count  = '0;
  assign bus.bubble_count = '0;
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: vector table, directed corner sequences and random run against a fetch reference model.
module tb_fetch_ctrl;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam int          DC   = 4;
  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] addr;
    logic [31:0] pc4;
    logic        valid;
    logic        halted;
  } vec_t;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] mem [0:15];
  logic [31:0] oob_word = HALT;
  int          checks = 0;
  int          errors = 0;
  vec_t        tbl [20];
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_halted, m_fault;
  int          m_left, m_fc, m_bc;
  fetch_ctrl_if bus();
  fetch_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always_comb bus.imem_instr = (bus.imem_addr < 32'd52) ? mem[bus.imem_addr[5:2]] : oob_word;
  function automatic logic [31:0] rd(input logic [31:0] a);
    return (a < 32'd52) ? mem[a[5:2]] : oob_word;
  endfunction
  function automatic vec_t v(input logic s, input logic b, input logic [31:0] t, input logic [31:0] a,
                             input logic [31:0] p, input logic vl, input logic h);
    vec_t r;
    r.stall = s; r.br = b; r.tgt = t; r.addr = a; r.pc4 = p; r.valid = vl; r.halted = h;
    return r;
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic m_reset();
    m_pc = 32'd0; m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
    m_halted = 1'b0; m_fault = 1'b0; m_left = 0; m_fc = 0; m_bc = 0;
  endtask
  // m_left counts bubble edges still owed before halted; 0 means fetching normally.
  task automatic model_step();
    logic ld, bub;
    ld = 1'b0; bub = 1'b0;
    if (!m_halted) begin
      if (bus.branch_taken) begin
        m_pc = {bus.branch_target[31:2], 2'b00}; m_left = 0; bub = 1'b1;
      end else if (m_left > 0) begin
        if (!bus.stall) begin
          bub = 1'b1; m_left--;
          if (m_left == 0) m_halted = 1'b1;
        end
      end else if (m_pc > 32'd48 || rd(m_pc) == HALT) begin
        if (m_pc > 32'd48) m_fault = 1'b1;
        bub = 1'b1; m_left = DC - 1;
        if (m_left == 0) m_halted = 1'b1;
      end else if (!bus.stall) ld = 1'b1;
    end
    if (bub) begin
      m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
      if (m_bc < 65535) m_bc++;
    end
    if (ld) begin
      m_instr = rd(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
      if (m_fc < 65535) m_fc++;
    end
  endtask
  task automatic check_all();
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("ifid_instr", bus.ifid_instr, m_instr);
    chk("ifid_pc4", bus.ifid_pc4, m_pc4);
    chk("ifid_valid", 32'(bus.ifid_valid), 32'(m_valid));
    chk("halted", 32'(bus.halted), 32'(m_halted));
    chk("fault", 32'(bus.fault), 32'(m_fault));
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_count", 32'(bus.fetch_count), 32'(m_fc));
    chk("bubble_count", 32'(bus.bubble_count), 32'(m_bc));
`else
    chk("fetch_count", 32'(bus.fetch_count), 32'd0);
    chk("bubble_count", 32'(bus.bubble_count), 32'd0);
`endif
  endtask
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask
  task automatic drive(input logic s, input logic b, input logic [31:0] t);
    bus.stall = s; bus.branch_taken = b; bus.branch_target = t;
  endtask
  // Asynchronous pulse between edges; outputs must clear before any clock edge.
  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1 m_reset();
    check_all();
    #1 reset = 1'b0;
  endtask
  task automatic fill_directed();
    for (int i = 0; i < 16; i++) mem[i] = (i < 8) ? 32'h2400_0000 + 32'(i) : 32'd0;
    mem[12] = HALT;
  endtask
  initial begin
    fill_directed();
    drive(1'b0, 1'b0, 32'd0);
    tbl[0]  = v(1'b0, 1'b0, 32'd0,  32'd4,  32'd4,  1'b1, 1'b0);
    tbl[1]  = v(1'b0, 1'b0, 32'd0,  32'd8,  32'd8,  1'b1, 1'b0);
    tbl[2]  = v(1'b1, 1'b0, 32'd0,  32'd8,  32'd8,  1'b1, 1'b0);
    tbl[3]  = v(1'b1, 1'b0, 32'd0,  32'd8,  32'd8,  1'b1, 1'b0);
    tbl[4]  = v(1'b1, 1'b0, 32'd0,  32'd8,  32'd8,  1'b1, 1'b0);
    tbl[5]  = v(1'b0, 1'b0, 32'd0,  32'd12, 32'd12, 1'b1, 1'b0);
    tbl[6]  = v(1'b1, 1'b1, 32'h13, 32'd16, 32'd0,  1'b0, 1'b0);
    for (int i = 7; i < 15; i++) tbl[i] = v(1'b0, 1'b0, 32'd0, 32'(4 * i - 8), 32'(4 * i - 8), 1'b1, 1'b0);
    tbl[15] = v(1'b0, 1'b0, 32'd0,  32'd48, 32'd0,  1'b0, 1'b0);
    tbl[16] = v(1'b0, 1'b0, 32'd0,  32'd48, 32'd0,  1'b0, 1'b0);
    tbl[17] = v(1'b0, 1'b0, 32'd0,  32'd48, 32'd0,  1'b0, 1'b0);
    tbl[18] = v(1'b0, 1'b0, 32'd0,  32'd48, 32'd0,  1'b0, 1'b1);
    tbl[19] = v(1'b1, 1'b1, 32'd0,  32'd48, 32'd0,  1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1 m_reset();
    check_all();
    #2 reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].stall, tbl[i].br, tbl[i].tgt);
      tick();
      chk($sformatf("vec%0d addr", i), bus.imem_addr, tbl[i].addr);
      chk($sformatf("vec%0d pc4", i), bus.ifid_pc4, tbl[i].pc4);
      chk($sformatf("vec%0d valid", i), 32'(bus.ifid_valid), 32'(tbl[i].valid));
      chk($sformatf("vec%0d halted", i), 32'(bus.halted), 32'(tbl[i].halted));
      chk($sformatf("vec%0d instr", i), bus.ifid_instr,
          tbl[i].valid ? mem[4'(tbl[i].pc4[5:2] - 4'd1)] : 32'd0);
    end
`ifdef FETCH_PERF_CNT_EN
    chk("table fetch_count", 32'(bus.fetch_count), 32'd11);
    chk("table bubble_count", 32'(bus.bubble_count), 32'd5);
`endif
    // Wrong-path halt: halt at 12, branch back to 4 in the second drain cycle.
    mem[3] = HALT;
    drive(1'b0, 1'b0, 32'd0);
    pulse_reset();
    repeat (5) tick();
    drive(1'b0, 1'b1, 32'd4);
    tick();
    chk("wrong_path addr", bus.imem_addr, 32'd4);
    chk("wrong_path halted", 32'(bus.halted), 32'd0);
    drive(1'b0, 1'b0, 32'd0);
    repeat (6) tick();
    chk("wrong_path final halted", 32'(bus.halted), 32'd1);
    // Fault: out-of-range fetch even though the word there is not a halt.
    fill_directed();
    oob_word = 32'h2400_00AA;
    pulse_reset();
    drive(1'b0, 1'b1, 32'd52);
    tick();
    chk("fault addr", bus.imem_addr, 32'd52);
    drive(1'b0, 1'b0, 32'd0);
    tick();
    chk("fault flag", 32'(bus.fault), 32'd1);
    repeat (2) tick();
    chk("fault not yet halted", 32'(bus.halted), 32'd0);
    tick();
    chk("fault halted", 32'(bus.halted), 32'd1);
    // Async reset in the middle of a fault drain, then fetch restarts from 0.
    pulse_reset();
    drive(1'b0, 1'b1, 32'd52);
    tick();
    drive(1'b0, 1'b0, 32'd0);
    repeat (2) tick();
    pulse_reset();
    chk("reset_drain fault", 32'(bus.fault), 32'd0);
    tick();
    chk("reset_drain pc4", bus.ifid_pc4, 32'd4);
    chk("reset_drain valid", 32'(bus.ifid_valid), 32'd1);
    // Random run: random program, stalls, branches (some out of range) and resets.
    for (int i = 0; i < 16; i++) mem[i] = ($urandom_range(0, 9) == 0) ? HALT : $urandom;
    for (int c = 0; c < 800; c++) begin
      if (m_halted || $urandom_range(0, 99) == 0) begin
        for (int i = 0; i < 16; i++) mem[i] = ($urandom_range(0, 9) == 0) ? HALT : $urandom;
        oob_word = ($urandom_range(0, 1) == 0) ? HALT : $urandom;
        pulse_reset();
      end
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
            ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 60)));
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
